aes_key_expander: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expander.sv | 192 +++++++++++++++++++
 tb/tb_aes_key_expander.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, FSM states,
// Nk/Nr lookup, round constants and the forward S-box.
package aes_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        KL_128  = 2'd0,
        KL_192  = 2'd1,
        KL_256  = 2'd2,
        KL_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2,
        ST_ZERO   = 2'd3
    } state_e;

    // Index 0 and 11..15 are never used; padding keeps any 4-bit index in range
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Key words Nk for a key_len code; reserved code maps to 8 and is rejected upstream
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        logic [3:0] nk;
        case (kl)
            KL_128:  nk = 4'd4;
            KL_192:  nk = 4'd6;
            default: nk = 4'd8;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return nk_of(kl) + 4'd6;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    assign o_byte_c = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: one word per clock into a word store, with a
// registered 128-bit round-key read port. AES_KEYEXP_ZEROIZE_EN adds i_zeroize.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
`ifdef AES_KEYEXP_ZEROIZE_EN
    input  logic           i_zeroize,
`endif
    input  logic [1:0]     i_key_len,
    input  logic [0:255]   i_key_in,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_ready,
    output logic           o_err,
    output logic [3:0]     o_num_rounds,
    input  logic           i_rk_rd,
    input  logic [3:0]     i_rk_idx,
    output logic [0:127]   o_rk_data,
    output logic           o_rk_valid
);

    localparam int unsigned MAX_NK = MAX_KEY_BITS / 32;
    localparam int unsigned DEPTH  = 4 * (MAX_NK + 7);
    localparam int unsigned CW     = $clog2(DEPTH);

    state_e              r_state;
    state_e              w_next_state;
    logic [WORD_W-1:0]   r_store [DEPTH];
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       r_last;
    logic [3:0]          r_nk;
    logic [2:0]          r_mod;
    logic [3:0]          r_rc;
    logic                r_busy, r_done, r_ready, r_err, r_rk_valid;
    logic [3:0]          r_num_rounds;
    logic [0:127]        r_rk_data;

    logic                w_zero;
    logic                w_legal, w_start_ok;
    logic [3:0]          w_nk_in;
    logic                w_accept, w_reject, w_exp_wr, w_last, w_zero_wr, w_rd_ok;
    logic [WORD_W-1:0]   w_prev, w_sb_in, w_sub, w_temp, w_new;
    logic [CW-1:0]       w_rd_base;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign w_zero = i_zeroize;
`else
    assign w_zero = 1'b0;
`endif

    assign w_nk_in    = nk_of(i_key_len);
    assign w_legal    = (i_key_len != KL_RSVD) && (32'(w_nk_in) <= MAX_NK);
    assign w_start_ok = i_start && w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_zero) begin
            w_next_state = ST_ZERO;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (w_start_ok) w_next_state = ST_EXPAND;
                ST_EXPAND:        if (r_cnt == r_last) w_next_state = ST_DONE;
                ST_ZERO:          if (r_cnt == CW'(DEPTH - 1)) w_next_state = ST_IDLE;
                default:          w_next_state = ST_IDLE;
            endcase
        end
    end

    // Start arriving during EXPAND is silently dropped; during a sweep it is an error
    always_comb begin
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_exp_wr  = 1'b0;
        w_zero_wr = 1'b0;
        if (!w_zero) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    w_accept = w_start_ok;
                    w_reject = i_start && !w_legal;
                end
                ST_EXPAND: w_exp_wr  = 1'b1;
                ST_ZERO: begin
                    w_zero_wr = 1'b1;
                    w_reject  = i_start;
                end
                default: ;
            endcase
        end
        w_last  = w_exp_wr && (r_cnt == r_last);
        w_rd_ok = i_rk_rd && r_ready && (i_rk_idx <= r_num_rounds) && !w_accept && !w_zero;
    end

    // Schedule word datapath: temp from w[i-1], xor with w[i-Nk]
    assign w_prev  = r_store[r_cnt - CW'(1)];
    assign w_sb_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte   (w_sb_in[8*b +: 8]),
            .o_byte_c (w_sub[8*b +: 8])
        );
    end

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0)                        w_temp = w_sub ^ {RCON[r_rc], 24'h0};
        else if ((r_nk == 4'd8) && (r_mod == 3'd4)) w_temp = w_sub;
        w_new = r_store[r_cnt - CW'(r_nk)] ^ w_temp;
    end

    // Store has no reset: contents are only meaningful while o_ready is high
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned j = 0; j < MAX_NK; j++) begin
                if (4'(j) < w_nk_in) r_store[CW'(j)] <= i_key_in[32*j +: 32];
            end
        end else if (w_exp_wr) begin
            r_store[r_cnt] <= w_new;
        end else if (w_zero_wr) begin
            r_store[r_cnt] <= '0;
        end
    end

    assign w_rd_base = CW'({i_rk_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_last       <= '0;
            r_nk         <= 4'd4;
            r_mod        <= '0;
            r_rc         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_num_rounds <= '0;
            r_rk_valid   <= 1'b0;
            r_rk_data    <= '0;
        end else begin
            r_busy     <= (w_next_state == ST_EXPAND) || (w_next_state == ST_ZERO);
            r_done     <= w_last;
            r_err      <= w_reject;
            r_rk_valid <= w_rd_ok;
            if (w_zero) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt  <= CW'(w_nk_in);
                r_last <= CW'({w_nk_in + 4'd7, 2'b00} - 6'd1);
                r_nk   <= w_nk_in;
                r_mod  <= '0;
                r_rc   <= 4'd1;
            end else if (w_exp_wr || w_zero_wr) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_exp_wr) begin
                    r_mod <= (r_mod == 3'(r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
                    if (r_mod == 3'd0) r_rc <= r_rc + 4'd1;
                end
            end
            if (w_zero || w_accept) begin
                r_ready      <= 1'b0;
                r_num_rounds <= '0;
            end else if (w_last) begin
                r_ready      <= 1'b1;
                r_num_rounds <= r_nk + 4'd6;
            end
            if (w_rd_ok) begin
                r_rk_data <= {r_store[w_rd_base],          r_store[w_rd_base + CW'(1)],
                              r_store[w_rd_base + CW'(2)], r_store[w_rd_base + CW'(3)]};
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_ready      = r_ready;
    assign o_err        = r_err;
    assign o_num_rounds = r_num_rounds;
    assign o_rk_valid   = r_rk_valid;
    assign o_rk_data    = r_rk_data;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start, i_rk_rd;
    logic [1:0]   i_key_len;
    logic [0:255] i_key_in;
    logic [3:0]   i_rk_idx;
    logic         o_busy, o_done, o_ready, o_err, o_rk_valid;
    logic [3:0]   o_num_rounds;
    logic [0:127] o_rk_data;

    logic         s_start, s_rk_rd;
    logic [1:0]   s_key_len;
    logic [0:255] s_key_in;
    logic [3:0]   s_rk_idx;
    logic         s_busy, s_done, s_ready, s_err, s_rk_valid;
    logic [3:0]   s_num_rounds;
    logic [0:127] s_rk_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_expander #(.MAX_KEY_BITS(256)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .i_zeroize    (1'b0),
`endif
        .i_key_len    (i_key_len),
        .i_key_in     (i_key_in),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ready      (o_ready),
        .o_err        (o_err),
        .o_num_rounds (o_num_rounds),
        .i_rk_rd      (i_rk_rd),
        .i_rk_idx     (i_rk_idx),
        .o_rk_data    (o_rk_data),
        .o_rk_valid   (o_rk_valid)
    );

    aes_key_expander #(.MAX_KEY_BITS(128)) u_dut128 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (s_start),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .i_zeroize    (1'b0),
`endif
        .i_key_len    (s_key_len),
        .i_key_in     (s_key_in),
        .o_busy       (s_busy),
        .o_done       (s_done),
        .o_ready      (s_ready),
        .o_err        (s_err),
        .o_num_rounds (s_num_rounds),
        .i_rk_rd      (s_rk_rd),
        .i_rk_idx     (s_rk_idx),
        .o_rk_data    (s_rk_data),
        .o_rk_valid   (s_rk_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_key(input logic [1:0] kl, input logic [0:255] key);
        i_start   = 1'b1;
        i_key_len = kl;
        i_key_in  = key;
        tick();
        i_start   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_done && n < 200);
    endtask

    task automatic rd(input logic [3:0] idx);
        i_rk_rd  = 1'b1;
        i_rk_idx = idx;
        tick();
        i_rk_rd  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic saw_err;
        i_start = 0; i_key_len = 0; i_key_in = '0; i_rk_rd = 0; i_rk_idx = 0;
        s_start = 0; s_key_len = 0; s_key_in = '0; s_rk_rd = 0; s_rk_idx = 0;
        repeat (2) tick();
        chk_b("rst_busy",  o_busy, 1'b0);
        chk_b("rst_ready", o_ready, 1'b0);
        chk_n("rst_nr",    int'(o_num_rounds), 0);
        chk_w("rst_data",  o_rk_data, 128'h0);
        rst_n = 1'b1;
        tick();

        // AES-128 expansion and latency
        start_key(2'd0, K128);
        chk_b("busy_128", o_busy, 1'b1);
        wait_done(n);
        chk_n("lat_128",   n, 40);
        chk_b("ready_128", o_ready, 1'b1);
        chk_b("idle_128",  o_busy, 1'b0);
        chk_n("nr_128",    int'(o_num_rounds), 10);
        tick();
        chk_b("done_pulse", o_done, 1'b0);

        // Back-to-back reads of every round key
        i_rk_rd  = 1'b1;
        i_rk_idx = 4'd0;
        for (int k = 0; k < 11; k++) begin
            tick();
            chk_b("b2b_valid", o_rk_valid, 1'b1);
            if (k == 0)  chk_w("rk128_0",  o_rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
            if (k == 1)  chk_w("rk128_1",  o_rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
            if (k == 2)  chk_w("rk128_2",  o_rk_data, 128'hf2c295f27a96b9435935807a7359f67f);
            if (k == 10) chk_w("rk128_10", o_rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            i_rk_idx = 4'(k + 1);
        end
        i_rk_rd = 1'b0;
        rd(4'd11);
        chk_b("idx11_valid", o_rk_valid, 1'b0);
        chk_w("idx11_hold",  o_rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reserved key_len rejected in DONE
        i_start = 1'b1; i_key_len = 2'd3; i_key_in = K256;
        tick();
        i_start = 1'b0;
        chk_b("rsvd_err",   o_err, 1'b1);
        chk_b("rsvd_busy",  o_busy, 1'b0);
        chk_b("rsvd_ready", o_ready, 1'b1);
        tick();
        chk_b("rsvd_err_pulse", o_err, 1'b0);
        rd(4'd10);
        chk_w("rsvd_store", o_rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Re-key to AES-192 with a coincident read, plus an ignored mid-expansion start
        i_start = 1'b1; i_key_len = 2'd1; i_key_in = K192;
        i_rk_rd = 1'b1; i_rk_idx = 4'd0;
        tick();
        i_start = 1'b0; i_rk_rd = 1'b0;
        chk_b("rekey_valid", o_rk_valid, 1'b0);
        chk_b("rekey_ready", o_ready, 1'b0);
        chk_b("rekey_busy",  o_busy, 1'b1);
        n = 0;
        saw_err = 1'b0;
        do begin
            if (n == 5) begin
                i_start = 1'b1; i_key_len = 2'd0; i_key_in = K128;
            end
            tick();
            i_start = 1'b0;
            n++;
            if (o_err) saw_err = 1'b1;
        end while (!o_done && n < 200);
        chk_n("lat_192",     n, 46);
        chk_b("exp_start_err", saw_err, 1'b0);
        chk_n("nr_192",      int'(o_num_rounds), 12);
        rd(4'd12);
        chk_w("rk192_12", o_rk_data, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd0);
        chk_w("rk192_0",  o_rk_data, 128'h8e73b0f7da0e6452c810f32b809079e5);

        // AES-256
        start_key(2'd2, K256);
        wait_done(n);
        chk_n("lat_256", n, 52);
        chk_n("nr_256",  int'(o_num_rounds), 14);
        rd(4'd14);
        chk_w("rk256_14", o_rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd1);
        chk_w("rk256_1",  o_rk_data, 128'h1f352c073b6108d72d9810a30914dff4);

        // Asynchronous reset mid AES-256 expansion
        start_key(2'd2, K256);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk_b("arst_busy",  o_busy, 1'b0);
        chk_b("arst_done",  o_done, 1'b0);
        chk_b("arst_ready", o_ready, 1'b0);
        chk_b("arst_err",   o_err, 1'b0);
        chk_b("arst_valid", o_rk_valid, 1'b0);
        chk_n("arst_nr",    int'(o_num_rounds), 0);
        chk_w("arst_data",  o_rk_data, 128'h0);
        #2 rst_n = 1'b1;
        tick();
        rd(4'd0);
        chk_b("arst_rd_valid", o_rk_valid, 1'b0);
        start_key(2'd0, K128);
        wait_done(n);
        chk_n("lat_128_after_rst", n, 40);
        rd(4'd10);
        chk_w("rk128_10_after_rst", o_rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // MAX_KEY_BITS=128 instance rejects 256-bit keys
        s_start = 1'b1; s_key_len = 2'd2; s_key_in = K256;
        tick();
        s_start = 1'b0;
        chk_b("m128_err",   s_err, 1'b1);
        chk_b("m128_busy",  s_busy, 1'b0);
        chk_b("m128_ready", s_ready, 1'b0);
        s_start = 1'b1; s_key_len = 2'd0; s_key_in = K128;
        tick();
        s_start = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_done && n < 200);
        chk_n("m128_lat", n, 40);
        s_start = 1'b1; s_key_len = 2'd2; s_key_in = K256;
        tick();
        s_start = 1'b0;
        chk_b("m128_err2",   s_err, 1'b1);
        chk_b("m128_ready2", s_ready, 1'b1);
        s_rk_rd = 1'b1; s_rk_idx = 4'd10;
        tick();
        s_rk_rd = 1'b0;
        chk_b("m128_valid", s_rk_valid, 1'b1);
        chk_w("m128_rk10",  s_rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
